// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the ID/EX hazard and stall controller.
// Holds default sizes, the R0 index and the muldiv sequencer state encoding.
package hazard_stall_ctrl_pkg;

  localparam int unsigned REG_NUM_WIDTH_DEF = 4;
  localparam int unsigned MULDIV_CYCLES_DEF = 8;
  localparam int unsigned CNT_WIDTH_DEF     = 4;
  localparam int unsigned PERF_WIDTH_DEF    = 16;

  // Multiply/divide results always land in R0
  localparam int unsigned R0_IDX = 0;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/hazard_stall_ctrl_muldiv_sequencer.sv
// Multiply/divide sequencer: tracks an in-flight muldiv and produces the
// one-cycle R0 write strobe when its result becomes valid.
// Ports:
//   clk, reset_n  clock and async active-low reset
//   issue         muldiv accepted this cycle (only honoured in IDLE)
//   busy          operation in flight (state is MD_BUSY)
//   write_r0      registered one-cycle strobe, high in the first IDLE cycle
module hazard_stall_ctrl_muldiv_sequencer
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = MULDIV_CYCLES_DEF,
  parameter int unsigned CNT_WIDTH     = CNT_WIDTH_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic issue,
  output logic busy,
  output logic write_r0
);

  md_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 write_r0_d;

  // State, countdown and strobe registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      write_r0 <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_r0 <= write_r0_d;
    end
  end

  // Next state: countdown from MULDIV_CYCLES-1, leave MD_BUSY when it hits 1
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_r0_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (issue) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_WIDTH'(MULDIV_CYCLES - 1);
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) begin
          state_d    = IDLE;
          write_r0_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID/EX hazard controller: inserts a single bubble for uncovered load-use
// hazards, issues and tracks the multi-cycle muldiv unit (result in R0),
// stalls dependents until the R0 write strobe, and counts stall cycles.
// Ports:
//   clk, reset_n                    clock and async active-low reset
//   rn_1_id, rn_2_id, use_rn_1/2    source operands of the ID instruction
//   id_is_muldiv                    ID instruction is a multiply/divide
//   rn_1_ex, ex_mem_read,
//   ex_write_reg                    destination / load info of EX instruction
//   flush                           IF/ID flush, suppresses stall and issue
//   stall_pc, stall_if_id,
//   bubble_id_ex                    combinational stall controls
//   muldiv_start                    combinational issue strobe
//   muldiv_busy                     muldiv operation in flight
//   write_r0                        registered one-cycle R0 write strobe
//   stall_cycles                    saturating stalled-cycle counter
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned REG_NUM_WIDTH = REG_NUM_WIDTH_DEF,
  parameter int unsigned MULDIV_CYCLES = MULDIV_CYCLES_DEF,
  parameter int unsigned CNT_WIDTH     = CNT_WIDTH_DEF,
  parameter int unsigned PERF_WIDTH    = PERF_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [REG_NUM_WIDTH-1:0] rn_1_id,
  input  logic [REG_NUM_WIDTH-1:0] rn_2_id,
  input  logic                     use_rn_1,
  input  logic                     use_rn_2,
  input  logic                     id_is_muldiv,
  input  logic [REG_NUM_WIDTH-1:0] rn_1_ex,
  input  logic                     ex_mem_read,
  input  logic                     ex_write_reg,
  input  logic                     flush,
  output logic                     stall_pc,
  output logic                     stall_if_id,
  output logic                     bubble_id_ex,
  output logic                     muldiv_start,
  output logic                     muldiv_busy,
  output logic                     write_r0,
  output logic [PERF_WIDTH-1:0]    stall_cycles
);

  localparam logic [REG_NUM_WIDTH-1:0] R0 = REG_NUM_WIDTH'(R0_IDX);

  logic hit_1, hit_2, load_use;
  logic reads_r0, r0_dep, stall;

  // Load-use: forwarding cannot supply a load result to the very next op
  assign hit_1    = use_rn_1 && (rn_1_id == rn_1_ex);
  assign hit_2    = use_rn_2 && (rn_2_id == rn_1_ex);
  assign load_use = ex_mem_read && ex_write_reg && (hit_1 || hit_2);

  // R0 dependency: any R0 reader or a second muldiv waits for the result
  assign reads_r0 = (use_rn_1 && (rn_1_id == R0)) || (use_rn_2 && (rn_2_id == R0));
  assign r0_dep   = muldiv_busy && (reads_r0 || id_is_muldiv);

  assign stall        = !flush && (load_use || r0_dep);
  assign stall_pc     = stall;
  assign stall_if_id  = stall;
  assign bubble_id_ex = stall;

  // Issue is held off by a load-use bubble; busy already covers r0_dep
  assign muldiv_start = !muldiv_busy && id_is_muldiv && !flush && !load_use;

  hazard_stall_ctrl_muldiv_sequencer #(
    .MULDIV_CYCLES (MULDIV_CYCLES),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_seq (
    .clk      (clk),
    .reset_n  (reset_n),
    .issue    (muldiv_start),
    .busy     (muldiv_busy),
    .write_r0 (write_r0)
  );

  // Saturating stall-cycle counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != {PERF_WIDTH{1'b1}})) begin
      stall_cycles <= stall_cycles + PERF_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus random
// traffic against a time-based reference model of the muldiv schedule.
module tb_hazard_stall_ctrl;

  localparam int RW  = 4;
  localparam int MDC = 8;
  localparam int CW  = 4;
  localparam int PW  = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [RW-1:0] rn_1_id, rn_2_id, rn_1_ex;
  logic          use_rn_1, use_rn_2, id_is_muldiv;
  logic          ex_mem_read, ex_write_reg, flush;
  logic          stall_pc, stall_if_id, bubble_id_ex;
  logic          muldiv_start, muldiv_busy, write_r0;
  logic [PW-1:0] stall_cycles;

  hazard_stall_ctrl #(
    .REG_NUM_WIDTH (RW),
    .MULDIV_CYCLES (MDC),
    .CNT_WIDTH     (CW),
    .PERF_WIDTH    (PW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rn_1_id      (rn_1_id),
    .rn_2_id      (rn_2_id),
    .use_rn_1     (use_rn_1),
    .use_rn_2     (use_rn_2),
    .id_is_muldiv (id_is_muldiv),
    .rn_1_ex      (rn_1_ex),
    .ex_mem_read  (ex_mem_read),
    .ex_write_reg (ex_write_reg),
    .flush        (flush),
    .stall_pc     (stall_pc),
    .stall_if_id  (stall_if_id),
    .bubble_id_ex (bubble_id_ex),
    .muldiv_start (muldiv_start),
    .muldiv_busy  (muldiv_busy),
    .write_r0     (write_r0),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int  n_assert = 0;
  int  n_fail   = 0;
  // Model: cycle index and the cycle in which the last muldiv issued
  longint cyc       = 0;
  longint issue_cyc = -1000;
  longint exp_cnt   = 0;
  // DUT values seen at the most recent sample point
  logic obs_stall, obs_start, obs_busy, obs_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_id(input int r1, input int r2, input logic u1, input logic u2,
                        input logic md);
    rn_1_id = RW'(r1); rn_2_id = RW'(r2);
    use_rn_1 = u1; use_rn_2 = u2; id_is_muldiv = md;
  endtask

  task automatic set_ex(input int r, input logic mr, input logic wr);
    rn_1_ex = RW'(r); ex_mem_read = mr; ex_write_reg = wr;
  endtask

  // One clock: check every output against the model mid-cycle, then advance
  task automatic do_cycle();
    logic lu, dep, st, busy_m, wr_m, start_m;
    @(negedge clk);
    // A muldiv issued in cycle c is busy in c+1..c+MDC-1, writes R0 in c+MDC
    busy_m  = (cyc > issue_cyc) && (cyc < issue_cyc + MDC);
    wr_m    = (cyc == issue_cyc + MDC);
    lu      = ex_mem_read && ex_write_reg &&
              ((use_rn_1 && rn_1_id == rn_1_ex) || (use_rn_2 && rn_2_id == rn_1_ex));
    dep     = busy_m && ((use_rn_1 && rn_1_id == 0) || (use_rn_2 && rn_2_id == 0) ||
                         id_is_muldiv);
    st      = !flush && (lu || dep);
    start_m = !busy_m && id_is_muldiv && !flush && !lu;
    chk("stall_pc",     32'(stall_pc),     32'(st));
    chk("stall_if_id",  32'(stall_if_id),  32'(st));
    chk("bubble_id_ex", 32'(bubble_id_ex), 32'(st));
    chk("muldiv_start", 32'(muldiv_start), 32'(start_m));
    chk("muldiv_busy",  32'(muldiv_busy),  32'(busy_m));
    chk("write_r0",     32'(write_r0),     32'(wr_m));
    chk("stall_cycles", 32'(stall_cycles), 32'(exp_cnt));
    obs_stall = stall_pc;
    obs_start = muldiv_start;
    obs_busy  = muldiv_busy;
    obs_wr    = write_r0;
    @(posedge clk);
    if (start_m) issue_cyc = cyc;
    if (st && exp_cnt != 64'hFFFF) exp_cnt++;
    cyc++;
    #1;
  endtask

  initial begin
    int n, k;
    longint wr1, st2;

    // Reset
    reset_n = 1'b0;
    flush = 1'b0;
    set_id(1, 2, 1'b0, 1'b0, 1'b0);
    set_ex(4, 1'b0, 1'b0);
    #3;
    chk("rst_busy",  32'(muldiv_busy),  32'd0);
    chk("rst_wr",    32'(write_r0),     32'd0);
    chk("rst_cnt",   32'(stall_cycles), 32'd0);
    chk("rst_stall", 32'(stall_pc),     32'd0);
    chk("rst_start", 32'(muldiv_start), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    do_cycle();

    // 1: load r3 in EX, ID uses r3 as operand 2 -> one bubble
    set_ex(3, 1'b1, 1'b1);
    set_id(7, 3, 1'b0, 1'b1, 1'b0);
    do_cycle();
    chk("t1_stall", 32'(obs_stall), 32'd1);
    set_ex(3, 1'b0, 1'b0);  // bubble now in EX
    do_cycle();
    chk("t1_release", 32'(obs_stall), 32'd0);
    chk("t1_count", 32'(stall_cycles), 32'd1);

    // 2: operand not used / EX not a load -> no stall
    set_ex(3, 1'b1, 1'b1);
    set_id(7, 3, 1'b0, 1'b0, 1'b0);
    do_cycle();
    chk("t2_nouse", 32'(obs_stall), 32'd0);
    set_ex(3, 1'b0, 1'b1);
    set_id(7, 3, 1'b0, 1'b1, 1'b0);
    do_cycle();
    chk("t2_noload", 32'(obs_stall), 32'd0);
    set_ex(0, 1'b0, 1'b0);

    // 3: muldiv issue, then an R0 reader stalls until write_r0
    set_id(5, 6, 1'b0, 1'b0, 1'b1);
    do_cycle();
    chk("t3_start", 32'(obs_start), 32'd1);
    set_id(0, 6, 1'b1, 1'b0, 1'b0);
    n = 0; k = 0;
    for (int i = 0; i < 20; i++) begin
      do_cycle();
      if (obs_busy) k++;
      if (!obs_stall) break;
      n++;
    end
    chk("t3_stall_len", 32'(n), 32'(MDC - 1));
    chk("t3_busy_len", 32'(k), 32'(MDC - 1));
    chk("t3_release_wr", 32'(obs_wr), 32'd1);
    set_id(9, 10, 1'b0, 1'b0, 1'b0);
    do_cycle();

    // 4: back-to-back muldivs; second issues in the write_r0 cycle
    set_id(5, 6, 1'b0, 1'b0, 1'b1);
    do_cycle();
    chk("t4_start1", 32'(obs_start), 32'd1);
    n = 0; wr1 = -1;
    for (int i = 0; i < 20; i++) begin
      do_cycle();
      if (obs_start) begin wr1 = obs_wr ? cyc - 1 : -1; break; end
      n++;
    end
    chk("t4_stall_len", 32'(n), 32'(MDC - 1));
    chk("t4_issue_on_wr", 32'(wr1 >= 0), 32'd1);
    set_id(5, 6, 1'b0, 1'b0, 1'b0);
    st2 = -1;
    for (int i = 0; i < 20; i++) begin
      do_cycle();
      if (obs_wr) begin st2 = cyc - 1; break; end
    end
    chk("t4_wr_spacing", 32'(st2 - wr1), 32'(MDC));

    // 5: flush suppresses stall and issue; in-flight muldiv still completes
    set_ex(3, 1'b1, 1'b1);
    set_id(3, 3, 1'b1, 1'b1, 1'b1);
    flush = 1'b1;
    do_cycle();
    chk("t5_stall", 32'(obs_stall), 32'd0);
    chk("t5_start", 32'(obs_start), 32'd0);
    flush = 1'b0;
    set_ex(0, 1'b0, 1'b0);
    set_id(5, 6, 1'b0, 1'b0, 1'b1);
    do_cycle();
    chk("t5_issue", 32'(obs_start), 32'd1);
    wr1 = cyc - 1;
    flush = 1'b1;
    set_id(0, 0, 1'b1, 1'b1, 1'b1);
    st2 = -1;
    for (int i = 0; i < 20; i++) begin
      do_cycle();
      if (obs_wr) begin st2 = cyc - 1; break; end
    end
    chk("t5_flush_wr", 32'(st2 - wr1), 32'(MDC));
    flush = 1'b0;
    set_id(5, 6, 1'b0, 1'b0, 1'b0);
    do_cycle();

    // 6: reset while countdown is 3 -> no write_r0 afterwards
    set_id(5, 6, 1'b0, 1'b0, 1'b1);
    do_cycle();
    set_id(5, 6, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) do_cycle();
    reset_n = 1'b0;
    issue_cyc = -1000;
    exp_cnt = 0;
    #2;
    chk("t6_busy", 32'(muldiv_busy), 32'd0);
    chk("t6_wr", 32'(write_r0), 32'd0);
    chk("t6_cnt", 32'(stall_cycles), 32'd0);
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      do_cycle();
      if (obs_wr) n++;
    end
    chk("t6_no_wr", 32'(n), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      set_id(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 5) == 0));
      set_ex(int'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 3) != 0));
      flush = 1'($urandom_range(0, 9) == 0);
      do_cycle();
    end

    // Saturation: permanent load-use hazard for more than 2^16 cycles
    flush = 1'b0;
    set_id(9, 10, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) do_cycle();
    set_ex(5, 1'b1, 1'b1);
    set_id(5, 9, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) do_cycle();
    chk("t6_saturate", 32'(stall_cycles), 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
